uart_rx_byte: RTL and testbench

UART receive front end for the CPU core: oversamples the asynchronous `UART_RX` pin and assembles 8N1 frames, LSB first, into bytes. It sits between the board pin and the program/data loader in `top_sub`. Completed bytes are offered on a valid/ready handshake backed by a one-entry holding buffer. Framing and overrun errors are flagged with single-cycle pulses.

---
 rtl/uart_rx_byte.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte -- oversampling 8N1 UART receiver with a one-entry output
// buffer and a valid/ready handshake toward the program/data loader.
//
// Optional feature: define UART_RX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit (8E1 framing). With the macro
// undefined the block is a plain 8N1 receiver.
//
// Bit timing: the start bit is re-checked WAIT/2 cycles after the falling
// edge, and every later bit is sampled WAIT cycles after the previous
// sample. Each sample lands near the middle of its bit cell.
module uart_rx_byte #(
    parameter  int WAIT  = 2603,
    localparam int CNT_W = $clog2(WAIT)
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       UART_RX,
    output logic [7:0] dout,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    // Receiver states
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd5;
`endif

    // Timer reload values; the timer counts down to zero and the sample is
    // taken on the edge where it reads zero, so a reload of N-1 gives N cycles.
    localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(WAIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(WAIT - 1);

    logic             rx_meta;
    logic             rx_s;
    logic [2:0]       state;
    logic [CNT_W-1:0] timer;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             tick;
    logic             par_fail;
    logic             stop_smp;
    logic             byte_ok;
    logic             byte_bad;

    assign tick = (timer == '0);

    // Frame outcome, decided on the edge that samples the stop bit. The
    // holding buffer and the error flags update on this same edge so that
    // valid / frame_err / overrun all appear in the same cycle.
    assign stop_smp = (state == S_STOP) && tick;
    assign byte_ok  = stop_smp && rx_s && !par_fail;
    assign byte_bad = stop_smp && (!rx_s || par_fail);

    // Busy covers the frame proper; a stuck-low line parked in BREAK is not
    // a frame in progress.
    assign busy = (state != S_IDLE) && (state != S_BREAK);

    // Two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= UART_RX;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_err;

    // Parity result captured at the parity sample and applied at the stop
    // sample, so a bad parity still waits for the stop bit before idling.
    always_ff @(posedge CLK) begin
        if (RST) begin
            par_err <= 1'b0;
        end else if (state == S_START) begin
            par_err <= 1'b0;
        end else if (state == S_PARITY && tick) begin
            par_err <= ^{shreg, rx_s};
        end
    end

    assign par_fail = par_err;
`else
    assign par_fail = 1'b0;
`endif

    // Receive FSM: bit timer, bit counter and LSB-first shift register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state <= S_START;
                        timer <= HALF_LD;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (rx_s) begin
                            // Line went back high before mid start bit: glitch
                            state <= S_IDLE;
                            timer <= '0;
                        end else begin
                            state   <= S_DATA;
                            timer   <= FULL_LD;
                            bit_cnt <= '0;
                        end
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shreg   <= {rx_s, shreg[7:1]};
                        timer   <= FULL_LD;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        state <= S_STOP;
                        timer <= FULL_LD;
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        // A low stop bit means a break or a bad frame; hold off
                        // until the line is released so no bytes are invented.
                        state <= rx_s ? S_IDLE : S_BREAK;
                        timer <= '0;
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    // One-entry holding buffer with valid/ready handshake and error pulses.
    // A new byte may load while the current one is consumed in the same
    // cycle; otherwise the buffered byte wins and the new one is dropped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dout      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= byte_bad;
            overrun   <= byte_ok && valid && !ready;
            if (byte_ok && (!valid || ready)) begin
                dout  <= shreg;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte -- directed bench for uart_rx_byte at WAIT=16.
// Build with UART_RX_PARITY_EN defined to exercise the 8E1 variant.
module tb_uart_rx_byte;

    localparam int W = 16;
    localparam int H = W / 2;
    // Pin edge to valid: 2 synchronizer cycles + detect + half bit + bit cells
`ifdef UART_RX_PARITY_EN
    localparam int LAT = H + 10 * W + 1 + 2;
`else
    localparam int LAT = H + 9 * W + 1 + 2;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       UART_RX = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] dout;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    uart_rx_byte #(.WAIT(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .UART_RX   (UART_RX),
        .dout      (dout),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge
    int         vrise_n = 0, vrise_cyc = 0, vhi_n = 0;
    int         fe_n = 0, fe_cyc = 0, ov_n = 0, ov_cyc = 0, busy_n = 0;
    logic [7:0] vrise_dout = 8'h00;
    logic       valid_q = 1'b0;

    always @(negedge CLK) begin
        valid_q <= valid;
        if (valid) vhi_n <= vhi_n + 1;
        if (valid && !valid_q) begin
            vrise_n    <= vrise_n + 1;
            vrise_cyc  <= cyc;
            vrise_dout <= dout;
        end
        if (frame_err) begin
            fe_n   <= fe_n + 1;
            fe_cyc <= cyc;
        end
        if (overrun) begin
            ov_n   <= ov_n + 1;
            ov_cyc <= cyc;
        end
        if (busy) busy_n <= busy_n + 1;
    end

    int total = 0;
    int bad = 0;
    int last_start = 0;
    int v0, h0, f0, o0, b0;
`ifdef UART_RX_PARITY_EN
    logic par_inv = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        v0 = vrise_n; h0 = vhi_n; f0 = fe_n; o0 = ov_n; b0 = busy_n;
    endtask

    task automatic send_bit(input logic b, input int n);
        UART_RX = b;
        repeat (n) @(negedge CLK);
    endtask

    task automatic idle(input int n);
        send_bit(1'b1, n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input int stop_len);
        last_start = cyc;
        send_bit(1'b0, W);
        for (int i = 0; i < 8; i++) send_bit(d[i], W);
`ifdef UART_RX_PARITY_EN
        send_bit(^d ^ par_inv, W);
`endif
        send_bit(stop_lvl, stop_len);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (4) @(negedge CLK);
        chk("rst_dout", dout, 8'h00);
        chk("rst_valid", valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fe", frame_err, 1'b0);
        chk("rst_ov", overrun, 1'b0);
        RST = 1'b0;

        // 0xA5 with ready held high: one-cycle valid at LAT
        ready = 1'b1;
        idle(100);
        snap();
        send_frame(8'hA5, 1'b1, W);
        idle(40);
        chk("a5_lat", vrise_cyc - last_start, LAT);
        chk("a5_dout", vrise_dout, 8'hA5);
        chk("a5_vld_cycles", vhi_n - h0, 1);
        chk("a5_fe", fe_n - f0, 0);
        chk("a5_ov", ov_n - o0, 0);

        // 5-cycle low glitch: busy for the half-bit check only
        snap();
        send_bit(1'b0, 5);
        idle(40);
        chk("glitch_busy", busy_n - b0, H);
        chk("glitch_vld", vrise_n - v0, 0);
        chk("glitch_fe", fe_n - f0, 0);

        // 0x3C with stop held low 40 cycles, then a clean 0x01
        snap();
        send_frame(8'h3C, 1'b0, 40);
        chk("brk_fe_lat", fe_cyc - last_start, LAT);
        idle(20);
        chk("brk_fe_cnt", fe_n - f0, 1);
        chk("brk_vld", vrise_n - v0, 0);
        send_frame(8'h01, 1'b1, W);
        idle(40);
        chk("after_brk_dout", vrise_dout, 8'h01);
        chk("after_brk_valid", valid, 1'b0);

        // ready low, 0x11 then 0x22 back to back: overrun, 0x11 kept
        ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1, W);
        send_frame(8'h22, 1'b1, W);
        idle(40);
        chk("ovr_dout", dout, 8'h11);
        chk("ovr_valid", valid, 1'b1);
        chk("ovr_cnt", ov_n - o0, 1);
        chk("ovr_lat", ov_cyc - last_start, LAT);
        chk("ovr_fe", fe_n - f0, 0);
        ready = 1'b1;
        @(negedge CLK);
        ready = 1'b0;
        chk("ovr_consumed", valid, 1'b0);

        // ready pulsed on the exact cycle the second byte completes
        snap();
        send_frame(8'h11, 1'b1, W);
        idle(20);
        chk("swap_first", dout, 8'h11);
        fork
            send_frame(8'h22, 1'b1, W);
            begin
                repeat (LAT - 1) @(negedge CLK);
                ready = 1'b1;
                @(negedge CLK);
                ready = 1'b0;
            end
        join
        idle(40);
        chk("swap_ov", ov_n - o0, 0);
        chk("swap_dout", dout, 8'h22);
        chk("swap_valid", valid, 1'b1);

        // Reset in the middle of data bit 4 of 0xFF, with 0x22 still buffered
        snap();
        fork
            send_frame(8'hFF, 1'b1, W);
            begin
                repeat (5 * W + H) @(negedge CLK);
                chk("mid_busy", busy, 1'b1);
                RST = 1'b1;
                @(negedge CLK);
                chk("mid_rst_dout", dout, 8'h00);
                chk("mid_rst_valid", valid, 1'b0);
                chk("mid_rst_busy", busy, 1'b0);
                chk("mid_rst_fe", frame_err, 1'b0);
                chk("mid_rst_ov", overrun, 1'b0);
                RST = 1'b0;
            end
        join
        idle(40);
        chk("mid_rst_novld", vrise_n - v0, 0);
        chk("mid_rst_nofe", fe_n - f0, 0);
        ready = 1'b1;
        send_frame(8'h5A, 1'b1, W);
        idle(40);
        chk("post_rst_dout", vrise_dout, 8'h5A);
        chk("post_rst_lat", vrise_cyc - last_start, LAT);

`ifdef UART_RX_PARITY_EN
        // 0x5A has even weight, so a parity bit of 1 is wrong
        snap();
        par_inv = 1'b1;
        send_frame(8'h5A, 1'b1, W);
        idle(40);
        par_inv = 1'b0;
        chk("par_fe", fe_n - f0, 1);
        chk("par_fe_lat", fe_cyc - last_start, LAT);
        chk("par_vld", vrise_n - v0, 0);
        chk("par_busy", busy, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
